sum_cmp_seq: RTL and testbench
==============================

# sum_cmp_seq

Streaming multi-term sum-and-compare unit for the arithmetic-comparator family of the 2022 CAD contest designs. The block accepts a packet of operand pairs over a valid/ready handshake and accumulates `a + b` per beat. At the end of the packet it compares the unsigned total against a threshold under a selectable relation and returns a one-bit verdict through a second valid/ready handshake. It generalises the fixed 3-bit + 4-bit "sum less than 9-bit" comparator to parametric widths, multi-beat packets, six compare modes and overflow reporting.

## Interface
- `A_W`, default 3: width of operand `a`.
- `B_W`, default 4: width of operand `b`.
- `T_W`, default 9: width of threshold.
- `ACC_W`, default 12: accumulator width. Must be ≥ max(T_W, max(A_W,B_W)+1); elaboration error otherwise.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: beat accepted when `in_valid & in_ready`.
- `in_a` in A_W: operand a (unsigned).
- `in_b` in B_W: operand b (unsigned).
- `in_thr` in T_W: threshold, sampled on the first beat of a packet only.
- `in_mode` in 3: relation, sampled on the first beat. 0 LT, 1 LE, 2 GT, 3 GE, 4 EQ, 5 NE, 6–7 reserved.
- `in_last` in 1: marks the final beat of the packet.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result consumed when `res_valid & res_ready`.
- `res_bit` out 1: verdict of `sum <mode> thr`.
- `res_ovf` out 1: the sum exceeded 2^ACC_W−1 at some point in the packet.
- `res_sum` out ACC_W: final accumulator value.

## Operation
- States: IDLE, ACC, HOLD.
- IDLE:
  - `in_ready`=1.
  - On accept: acc ← a+b (zero-extended), thr ← in_thr, mode ← in_mode, ovf ← 0.
  - Next state is HOLD if `in_last`, else ACC.
- ACC:
  - `in_ready`=1.
  - On accept: acc ← acc + a + b, computed at ACC_W+1 bits; ovf ← ovf | carry-out.
  - `in_thr` and `in_mode` are ignored.
  - Go to HOLD on `in_last`.
- Entry to HOLD:
  - Register `res_bit` = relation(acc_final, zero-extended thr).
  - Register `res_sum` = acc_final and `res_ovf` = ovf.
  - Set `res_valid`=1.
- HOLD:
  - `in_ready`=0.
  - `res_*` are held stable until the result handshake.
  - On `res_valid & res_ready` → IDLE, and `res_valid` falls.
- All comparisons are unsigned. Reserved modes 6–7 force `res_bit`=0; `res_sum` and `res_ovf` remain valid.
- `in_valid` low in ACC: hold state, acc unchanged. There is no timeout.
- Reset (any state, including mid-packet): immediate return to IDLE. acc, thr, mode and ovf clear. The partial packet is discarded.

## Timing
- Reset values: `in_ready`=0 while `rst` is high, 1 on the first cycle after release. `res_valid`=0, `res_bit`=0, `res_ovf`=0, `res_sum`=0.
- Throughput: one beat per cycle in IDLE/ACC.
- Latency: `res_valid` rises on the cycle after the `in_last` beat is accepted.
- Turnaround: after the result handshake at edge N, `in_ready`=1 from edge N. The first beat of the next packet is accepted no earlier than the cycle after the handshake. Minimum packet-to-packet spacing is 2 cycles for a single-beat packet.
- `in_ready` is a registered function of state only. It never combinationally depends on `in_valid` or `res_ready`.
- Outputs change only on `clk` rising edge or on `rst` assertion.

## Configuration
- `SUM_CMP_SAT_EN` defined: the accumulator saturates at 2^ACC_W−1 on carry-out and stays there for the rest of the packet. `res_sum` = all-ones on overflow.
- `SUM_CMP_SAT_EN` undefined: the accumulator wraps modulo 2^ACC_W.
- `res_ovf` is a sticky flag in both builds. Compare operates on the stored (saturated or wrapped) value.

## Test plan
- Single beat: a=3, b=5, thr=9, mode LT → `res_bit`=1, `res_sum`=8. Then a=4, b=5, thr=9, LT → `res_bit`=0, `res_sum`=9.
- Three beats of (7,15), thr=66 → sum 66. LE→1, GT→0, EQ→1, NE→0, GE→1. Also check that thr/mode changed on beats 2–3 are ignored.
- Backpressure:
  - Hold `res_ready`=0 for 5 cycles after result → `res_valid`=1 with `res_bit`/`res_sum` stable and `in_ready`=0.
  - `in_valid` held high is not accepted.
  - On release, the next packet's first beat is accepted one cycle later.
- Overflow, ACC_W=12, 200 beats of (7,15) = 4400:
  - With `SUM_CMP_SAT_EN`: `res_sum`=4095, `res_ovf`=1.
  - Without it: `res_sum`=304, `res_ovf`=1.
  - With thr=300, GT → 1 (sat build), 1 (wrap build).
- Reset mid-packet: assert `rst` after 2 beats of a 4-beat packet → all outputs 0 immediately. A new single-beat packet (1,1), thr=2, EQ yields `res_sum`=2, `res_bit`=1, `res_ovf`=0.
- Reserved mode 6 with a=0, b=0, thr=0 → `res_bit`=0, `res_sum`=0. Mode EQ with same operands → `res_bit`=1.

Source files
------------

// File: rtl/sum_cmp_seq_if.sv
// Operand-beat and result handshake bundle for sum_cmp_seq.
// master drives beats and consumes results; slave is the accumulator.
interface sum_cmp_seq_if #(
  parameter int A_W   = 3,
  parameter int B_W   = 4,
  parameter int T_W   = 9,
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic [T_W-1:0]   in_thr;
  logic [2:0]       in_mode;
  logic             in_last;
  logic             res_valid;
  logic             res_ready;
  logic             res_bit;
  logic             res_ovf;
  logic [ACC_W-1:0] res_sum;

  modport master (
    output in_valid, in_a, in_b, in_thr, in_mode, in_last, res_ready,
    input  in_ready, res_valid, res_bit, res_ovf, res_sum
  );

  modport slave (
    input  in_valid, in_a, in_b, in_thr, in_mode, in_last, res_ready,
    output in_ready, res_valid, res_bit, res_ovf, res_sum
  );
endinterface

// File: rtl/sum_cmp_seq.sv
// Streaming sum-of-(a+b) accumulator with unsigned compare against a threshold.
// Define SUM_CMP_SAT_EN to saturate the accumulator instead of wrapping.
module sum_cmp_seq #(
  parameter int A_W   = 3,
  parameter int B_W   = 4,
  parameter int T_W   = 9,
  parameter int ACC_W = 12
) (
  input logic          clk,
  input logic          rst,
  sum_cmp_seq_if.slave io
);
  localparam int S_W   = ACC_W + 1;
  localparam int OP_W  = ((A_W > B_W) ? A_W : B_W) + 1;

  generate
    if (ACC_W < T_W || ACC_W < OP_W) begin : g_bad_width
      $error("sum_cmp_seq: ACC_W must be >= max(T_W, max(A_W,B_W)+1)");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  typedef enum logic [2:0] {
    M_LT, M_LE, M_GT, M_GE, M_EQ, M_NE, M_RSV6, M_RSV7
  } mode_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [T_W-1:0]   thr_q, thr_d;
  mode_t            mode_q, mode_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             res_bit_q, res_bit_d;
  logic             res_ovf_q, res_ovf_d;
  logic [ACC_W-1:0] res_sum_q, res_sum_d;

  logic             accept;
  logic             first;
  logic [ACC_W-1:0] base;
  logic [S_W-1:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic [T_W-1:0]   thr_eff;
  mode_t            mode_eff;
  logic             ovf_eff;

  function automatic logic relate(input mode_t m,
                                  input logic [ACC_W-1:0] x,
                                  input logic [ACC_W-1:0] y);
    case (m)
      M_LT:    return x <  y;
      M_LE:    return x <= y;
      M_GT:    return x >  y;
      M_GE:    return x >= y;
      M_EQ:    return x == y;
      M_NE:    return x != y;
      default: return 1'b0;
    endcase
  endfunction

  // Datapath: the first beat starts from zero and takes thr/mode from the
  // bus directly, so a single-beat packet can be judged on the same edge.
  always_comb begin
    accept   = io.in_valid & in_ready_q;
    first    = (state_q == IDLE);
    base     = first ? '0 : acc_q;
    sum_ext  = {1'b0, base} + S_W'(io.in_a) + S_W'(io.in_b);
    carry    = sum_ext[ACC_W];
`ifdef SUM_CMP_SAT_EN
    acc_next = carry ? '1 : sum_ext[ACC_W-1:0];
`else
    acc_next = sum_ext[ACC_W-1:0];
`endif
    thr_eff  = first ? io.in_thr : thr_q;
    mode_eff = first ? mode_t'(io.in_mode) : mode_q;
    ovf_eff  = (first ? 1'b0 : ovf_q) | carry;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    thr_d       = thr_q;
    mode_d      = mode_q;
    ovf_d       = ovf_q;
    res_valid_d = res_valid_q;
    res_bit_d   = res_bit_q;
    res_ovf_d   = res_ovf_q;
    res_sum_d   = res_sum_q;

    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d  = acc_next;
          thr_d  = thr_eff;
          mode_d = mode_eff;
          ovf_d  = ovf_eff;
          if (io.in_last) begin
            state_d     = HOLD;
            res_valid_d = 1'b1;
            res_bit_d   = relate(mode_eff, acc_next, ACC_W'(thr_eff));
            res_ovf_d   = ovf_eff;
            res_sum_d   = acc_next;
          end else begin
            state_d = ACC;
          end
        end
      end
      HOLD: begin
        if (io.res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d != HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      thr_q       <= '0;
      mode_q      <= M_LT;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_bit_q   <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      thr_q       <= thr_d;
      mode_q      <= mode_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_bit_q   <= res_bit_d;
      res_ovf_q   <= res_ovf_d;
      res_sum_q   <= res_sum_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.res_valid = res_valid_q;
  assign io.res_bit   = res_bit_q;
  assign io.res_ovf   = res_ovf_q;
  assign io.res_sum   = res_sum_q;
endmodule

// File: tb/tb_sum_cmp_seq.sv
// Randomised and directed bench for sum_cmp_seq against an arithmetic model.
// Follows SUM_CMP_SAT_EN the same way the design does.
module tb_sum_cmp_seq;
  localparam int A_W   = 3;
  localparam int B_W   = 4;
  localparam int T_W   = 9;
  localparam int ACC_W = 12;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  int unsigned qa[$];
  int unsigned qb[$];

  sum_cmp_seq_if #(.A_W(A_W), .B_W(B_W), .T_W(T_W), .ACC_W(ACC_W)) bus ();

  sum_cmp_seq #(.A_W(A_W), .B_W(B_W), .T_W(T_W), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: the packet's true total, then wrap/saturate, then the relation.
  task automatic model(input longint thr, input int mode,
                       output logic exp_bit, output longint exp_sum, output logic exp_ovf);
    longint total = 0;
    longint maxv  = (longint'(1) << ACC_W) - 1;
    foreach (qa[i]) total += longint'(qa[i]) + longint'(qb[i]);
    exp_ovf = (total > maxv);
`ifdef SUM_CMP_SAT_EN
    exp_sum = exp_ovf ? maxv : total;
`else
    exp_sum = total % (maxv + 1);
`endif
    case (mode)
      0: exp_bit = exp_sum <  thr;
      1: exp_bit = exp_sum <= thr;
      2: exp_bit = exp_sum >  thr;
      3: exp_bit = exp_sum >= thr;
      4: exp_bit = exp_sum == thr;
      5: exp_bit = exp_sum != thr;
      default: exp_bit = 1'b0;
    endcase
  endtask

  // Entered and left at a falling edge; returns cycles spent waiting for ready.
  task automatic drive_beat(input int unsigned a, input int unsigned b, input logic last,
                            input int unsigned thr, input int unsigned mode, output int waited);
    bus.in_valid = 1'b1;
    bus.in_a     = A_W'(a);
    bus.in_b     = B_W'(b);
    bus.in_last  = last;
    bus.in_thr   = T_W'(thr);
    bus.in_mode  = 3'(mode);
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("in_ready_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_result(input logic exp_bit, input longint exp_sum,
                               input logic exp_ovf, input int hold);
    check("res_valid_latency", bus.res_valid, 1);
    check("in_ready_in_hold", bus.in_ready, 0);
    check("res_bit", bus.res_bit, exp_bit);
    check("res_sum", bus.res_sum, exp_sum);
    check("res_ovf", bus.res_ovf, exp_ovf);
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = A_W'($urandom);
      bus.in_b     = B_W'($urandom);
      bus.in_last  = 1'($urandom);
      @(negedge clk);
      check("hold_valid", bus.res_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_sum", bus.res_sum, exp_sum);
      check("hold_bit", bus.res_bit, exp_bit);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("res_valid_drop", bus.res_valid, 0);
    check("in_ready_turnaround", bus.in_ready, 1);
  endtask

  // Beats come from qa/qb; later beats carry junk thr/mode that must be ignored.
  task automatic run_pkt(input int unsigned thr, input int unsigned mode,
                         input int gapmax, input int hold, output int first_wait);
    logic   eb, eo;
    longint es;
    int     w;
    model(longint'(thr), int'(mode), eb, es, eo);
    first_wait = 0;
    foreach (qa[i]) begin
      if (i > 0) repeat ($urandom_range(0, gapmax)) @(negedge clk);
      drive_beat(qa[i], qb[i], i == qa.size() - 1,
                 (i == 0) ? thr : $urandom, (i == 0) ? mode : $urandom_range(0, 7), w);
      if (i == 0) first_wait = w;
    end
    finish_result(eb, es, eo, hold);
    qa.delete();
    qb.delete();
  endtask

  task automatic push(input int unsigned a, input int unsigned b);
    qa.push_back(a);
    qb.push_back(b);
  endtask

  initial begin
    int fw;
    int len;
    int mode_tab[5] = '{1, 2, 4, 5, 3};
    n_checks = 0;
    n_fail   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_thr    = '0;
    bus.in_mode   = '0;
    bus.in_last   = 1'b0;
    bus.res_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_bit", bus.res_bit, 0);
    check("rst_res_ovf", bus.res_ovf, 0);
    check("rst_res_sum", bus.res_sum, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);

    push(3, 5); run_pkt(9, 0, 0, 0, fw);
    push(4, 5); run_pkt(9, 0, 0, 0, fw);

    foreach (mode_tab[m]) begin
      repeat (3) push(7, 15);
      run_pkt(66, mode_tab[m], 2, 0, fw);
    end

    // Backpressure, then the next packet's first beat must go straight in.
    push(2, 9); push(6, 1); run_pkt(17, 3, 0, 5, fw);
    push(5, 5); run_pkt(10, 4, 0, 0, fw);
    check("next_beat_wait", fw, 0);

    repeat (200) push(7, 15);
    run_pkt(300, 2, 0, 2, fw);

    // Reset part-way through a 4-beat packet.
    drive_beat(3, 4, 0, 100, 0, fw);
    drive_beat(5, 6, 0, 100, 0, fw);
    bus.in_valid = 1'b1;
    bus.in_a     = 3'd1;
    bus.in_b     = 4'd2;
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_res_valid", bus.res_valid, 0);
    check("midrst_res_sum", bus.res_sum, 0);
    check("midrst_res_ovf", bus.res_ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("midrst_recover_ready", bus.in_ready, 1);
    push(1, 1); run_pkt(2, 4, 0, 0, fw);

    push(0, 0); run_pkt(0, 6, 0, 1, fw);
    push(0, 0); run_pkt(0, 4, 0, 0, fw);

    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++)
        push($urandom_range(0, (1 << A_W) - 1), $urandom_range(0, (1 << B_W) - 1));
      run_pkt($urandom_range(0, (1 << T_W) - 1), $urandom_range(0, 7), 2,
              $urandom_range(0, 3), fw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
